// File: rtl/mod_frame_arb.sv
// Frame arbiter: grants the shared 8b->5b packer to one of two byte sources per frame, round-robin.
// Latency: grant 1 cycle after req seen in IDLE, first byte offered the cycle after; frame_done 1 cycle after last symbol.
// Backpressure: bytes move only on out_vld & out_take; next grant waits until the packer drains all symbols.
module mod_frame_arb #(
    parameter int FRAME_BYTES = 5
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] req,
    input  logic [7:0] din0,
    input  logic [7:0] din1,
    output logic       pop0,
    output logic       pop1,
    output logic [1:0] gnt,
    output logic [7:0] out_data,
    output logic       out_vld,
    input  logic       out_take,
    input  logic       sym_en,
    output logic       frame_done,
    output logic       err
);

    localparam int SYMS_PER_FRAME = FRAME_BYTES * 8 / 5;
    localparam int BW = (FRAME_BYTES > 1) ? $clog2(FRAME_BYTES) : 1;
    localparam int SW = $clog2(SYMS_PER_FRAME + 1);
    localparam logic [BW-1:0] LAST_BYTE = BW'(FRAME_BYTES - 1);
    localparam logic [SW-1:0] SYM_FULL  = SW'(SYMS_PER_FRAME);
    localparam logic [SW-1:0] SYM_LAST  = SW'(SYMS_PER_FRAME - 1);

    typedef enum logic [2:0] {IDLE, GRANT, XFER, DRAIN, DONE} state_t;

    state_t        state;
    logic [BW-1:0] byte_cnt;
    logic [SW-1:0] sym_cnt;
    logic          winner;
    logic          last_served;

    logic xfer;
    logic pick;
    logic sym_ok;
    logic last_xfer;
    logic sym_full_nxt;

    assign xfer      = out_vld & out_take;
    assign pop0      = xfer & gnt[0];
    assign pop1      = xfer & gnt[1];
    assign out_data  = out_vld ? (gnt[1] ? din1 : din0) : 8'h00;
    // Requester 1 wins when alone, or on contention when requester 0 was served last.
    assign pick      = req[1] & (~req[0] | ~last_served);
    assign sym_ok    = (state == XFER) || (state == DRAIN);
    assign last_xfer = xfer && (byte_cnt == LAST_BYTE);
    // Packer may already be fully drained (counting this cycle's symbol) when the last byte leaves.
    assign sym_full_nxt = (sym_cnt == SYM_FULL) || (sym_en && sym_ok && (sym_cnt == SYM_LAST));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            gnt         <= 2'b00;
            out_vld     <= 1'b0;
            frame_done  <= 1'b0;
            err         <= 1'b0;
            byte_cnt    <= '0;
            sym_cnt     <= '0;
            winner      <= 1'b0;
            last_served <= 1'b1;
        end else begin
            frame_done <= 1'b0;

            if (sym_en && (!sym_ok || (sym_cnt == SYM_FULL)))
                err <= 1'b1;
            if (out_take && !out_vld)
                err <= 1'b1;

            if (sym_en && sym_ok && (sym_cnt != SYM_FULL))
                sym_cnt <= sym_cnt + 1'b1;

            case (state)
                IDLE: begin
                    if (req != 2'b00) begin
                        winner <= pick;
                        gnt    <= pick ? 2'b10 : 2'b01;
                        state  <= GRANT;
                    end
                end
                GRANT: begin
                    byte_cnt <= '0;
                    sym_cnt  <= '0;
                    out_vld  <= 1'b1;
                    state    <= XFER;
                end
                XFER: begin
                    if (xfer)
                        byte_cnt <= byte_cnt + 1'b1;
                    if (last_xfer) begin
                        out_vld <= 1'b0;
                        if (sym_full_nxt) begin
                            frame_done <= 1'b1;
                            state      <= DONE;
                        end else begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (sym_en && (sym_cnt == SYM_LAST)) begin
                        frame_done <= 1'b1;
                        state      <= DONE;
                    end
                end
                DONE: begin
                    last_served <= winner;
                    gnt         <= 2'b00;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
